// File: rtl/param_pipeline_alu.sv
// Three-stage ID/EX/WB integer pipeline with full EX/WB forwarding, a
// multi-cycle MUL that holds issue, and observable retire/debug state.
module param_pipeline_alu #(
  parameter int DW      = 8,
  parameter int NREG    = 4,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 16,
  localparam int RW     = $clog2(NREG),
  localparam int IW     = 3 + 3 * RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [IW-1:0]    inst,
  input  logic [RW-1:0]    dbg_rd_addr,
  output logic [DW-1:0]    dbg_rd_data,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MUL = 3'd6,
    OP_LI  = 3'd7
  } op_e;

  logic [DW-1:0]    rf_q [NREG];
  logic [DW-1:0]    rf_d [NREG];
  logic             ex_valid_q, ex_valid_d;
  op_e              ex_op_q, ex_op_d;
  logic [RW-1:0]    ex_rd_q, ex_rd_d;
  logic [DW-1:0]    ex_a_q, ex_a_d;
  logic [DW-1:0]    ex_b_q, ex_b_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RW-1:0]    wb_rd_q, wb_rd_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  op_e           id_op;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_a, id_b, id_imm;
  logic [DW-1:0] ex_result;
  logic          ex_busy;
  logic          accept;

  assign id_op  = op_e'(inst[IW-1 -: 3]);
  assign id_rs1 = inst[3*RW-1 -: RW];
  assign id_rs2 = inst[2*RW-1 -: RW];
  assign id_rd  = inst[RW-1:0];
  assign id_imm = DW'({id_rs1, id_rs2});

  assign ex_busy    = ex_valid_q && (ex_op_q == OP_MUL) && (mul_cnt_q != '0);
  assign inst_ready = !ex_busy;
  assign accept     = inst_valid && inst_ready && !rst;

  always_comb begin
    ex_result = '0;
    case (ex_op_q)
      OP_ADD:  ex_result = ex_a_q + ex_b_q;
      OP_SUB:  ex_result = ex_a_q - ex_b_q;
      OP_AND:  ex_result = ex_a_q & ex_b_q;
      OP_OR:   ex_result = ex_a_q | ex_b_q;
      OP_XOR:  ex_result = ex_a_q ^ ex_b_q;
      OP_MUL:  ex_result = ex_a_q * ex_b_q;
      OP_LI:   ex_result = ex_a_q;
      default: ex_result = '0;
    endcase
  end

  // EX is checked after WB so the younger producer wins on a shared rd.
  always_comb begin
    id_a = rf_q[id_rs1];
    id_b = rf_q[id_rs2];
    if (wb_valid_q && wb_rd_q == id_rs1) id_a = wb_data_q;
    if (wb_valid_q && wb_rd_q == id_rs2) id_b = wb_data_q;
    if (ex_valid_q && ex_rd_q == id_rs1) id_a = ex_result;
    if (ex_valid_q && ex_rd_q == id_rs2) id_b = ex_result;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    mul_cnt_d  = mul_cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    retire_d   = retire_q;
    rf_d       = rf_q;

    if (ex_busy) begin
      mul_cnt_d = mul_cnt_q - CW'(1);
    end else begin
      // NOPs enter EX as bubbles so they can never forward or write.
      ex_valid_d = accept && (id_op != OP_NOP);
      mul_cnt_d  = '0;
      if (accept) begin
        ex_op_d = id_op;
        ex_rd_d = id_rd;
        ex_a_d  = (id_op == OP_LI) ? id_imm : id_a;
        ex_b_d  = id_b;
        if (id_op == OP_MUL) mul_cnt_d = CW'(MUL_LAT - 1);
      end
      if (ex_valid_q) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = ex_rd_q;
        wb_data_d  = ex_result;
      end
    end

    if (wb_valid_q) begin
      rf_d[wb_rd_q] = wb_data_q;
      retire_d      = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      mul_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      retire_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      mul_cnt_q  <= mul_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
    end
  end

  // EX datapath is qualified by ex_valid_q and needs no reset.
  always_ff @(posedge clk) begin
    ex_op_q <= ex_op_d;
    ex_rd_q <= ex_rd_d;
    ex_a_q  <= ex_a_d;
    ex_b_q  <= ex_b_d;
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (rst) rf_q[gi] <= '0;
      else     rf_q[gi] <= rf_d[gi];
    end
  end

  assign dbg_rd_data = rf_q[dbg_rd_addr];
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_param_pipeline_alu.sv
// Scoreboard bench: an in-order architectural model predicts each register
// write and the cycle it must appear on the WB port.
module tb_param_pipeline_alu;

  localparam int DW      = 8;
  localparam int NREG    = 4;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 16;
  localparam int RW      = 2;
  localparam int IW      = 3 + 3 * RW;
  localparam int MASK    = (1 << DW) - 1;

  localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5, MUL = 6, LI = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inst_valid = 1'b0;
  logic             inst_ready;
  logic [IW-1:0]    inst = '0;
  logic [RW-1:0]    dbg_rd_addr = '0;
  logic [DW-1:0]    dbg_rd_data;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic [CNT_W-1:0] retire_cnt;

  param_pipeline_alu #(
    .DW(DW), .NREG(NREG), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    int rd;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   m_rf [NREG];
  int   stall_left = 0;
  int   retire_exp = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_exec(input int op, input int a, input int b, input int rs1, input int rs2);
    case (op)
      ADD:     return (a + b) & MASK;
      SUB:     return (a - b) & MASK;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      MUL:     return (a * b) & MASK;
      LI:      return ((rs1 << RW) | rs2) & MASK;
      default: return 0;
    endcase
  endfunction

  // Monitor: checks ready, retire count and the WB port every cycle, then
  // advances the architectural model on each accepted instruction.
  always @(negedge clk) begin : mon
    int op, rs1, rs2, rd, res;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NREG; i++) m_rf[i] = 0;
      stall_left = 0;
      retire_exp = 0;
    end else begin
      cmp("inst_ready", 64'(inst_ready), 64'(stall_left == 0));
      cmp("retire_cnt", 64'(retire_cnt), 64'(retire_exp & ((1 << CNT_W) - 1)));
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        cmp("wb_valid", 64'(wb_valid), 64'(1));
        cmp("wb_rd", 64'(wb_rd), 64'(e.rd));
        cmp("wb_data", 64'(wb_data), 64'(e.data));
        $display("WB  cyc %0d: r%0d <= 0x%0h", cyc, wb_rd, wb_data);
        retire_exp++;
      end else begin
        cmp("wb_valid_idle", 64'(wb_valid), 64'(0));
      end
      if (stall_left > 0) stall_left--;
      if (inst_valid && inst_ready) begin
        op  = int'(inst[IW-1 -: 3]);
        rs1 = int'(inst[3*RW-1 -: RW]);
        rs2 = int'(inst[2*RW-1 -: RW]);
        rd  = int'(inst[RW-1:0]);
        $display("ISS cyc %0d: op=%0d rs1=%0d rs2=%0d rd=%0d", cyc, op, rs1, rs2, rd);
        if (op != NOP) begin
          res = model_exec(op, m_rf[rs1], m_rf[rs2], rs1, rs2);
          e.rd   = rd;
          e.data = res;
          e.due  = cyc + ((op == MUL) ? MUL_LAT + 1 : 2);
          q.push_back(e);
          m_rf[rd] = res;
        end
        if (op == MUL) stall_left = MUL_LAT - 1;
      end
    end
  end

  // Driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input int op, input int rs1, input int rs2, input int rd);
    int guard;
    guard = 0;
    inst_valid = 1'b1;
    inst = {3'(op), RW'(rs1), RW'(rs2), RW'(rd)};
    @(negedge clk);
    while (!inst_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!inst_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: inst_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  task automatic li(input int v, input int rd);
    send(LI, (v >> RW) & (NREG - 1), v & (NREG - 1), rd);
  endtask

  task automatic idle(input int n);
    inst_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_reg(input int addr, input int val);
    dbg_rd_addr = RW'(addr);
    @(negedge clk);
    cmp($sformatf("dbg_r%0d", addr), 64'(dbg_rd_data), 64'(val));
    @(posedge clk);
    #1;
  endtask

  task automatic check_model_regs();
    int v;
    for (int i = 0; i < NREG; i++) begin
      v = m_rf[i];
      expect_reg(i, v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cmp("rst_wb_valid", 64'(wb_valid), 64'(0));
    cmp("rst_wb_rd", 64'(wb_rd), 64'(0));
    cmp("rst_wb_data", 64'(wb_data), 64'(0));
    cmp("rst_retire", 64'(retire_cnt), 64'(0));
    cmp("rst_ready", 64'(inst_ready), 64'(1));
    for (int i = 0; i < NREG; i++) expect_reg(i, 0);
  endtask

  initial begin
    int op, gap;
    do_reset();

    // Dependent back-to-back sequence.
    do_reset();
    li(5, 1); li(3, 2); send(ADD, 1, 2, 3); send(SUB, 2, 1, 0);
    idle(6);
    expect_reg(3, 8); expect_reg(0, 'hFE);
    cmp("s2_retire", 64'(retire_cnt), 64'(4));
    check_model_regs();

    // Same-rd priority: EX result must beat the older WB value.
    do_reset();
    li(2, 1); li(4, 1); send(ADD, 1, 1, 2);
    idle(6);
    expect_reg(2, 8); expect_reg(1, 4);

    // Chained multiplies with stalls.
    do_reset();
    li(15, 1); send(MUL, 1, 1, 2); send(MUL, 2, 2, 3); send(ADD, 3, 1, 0);
    idle(8);
    expect_reg(2, 225); expect_reg(3, 'hC1); expect_reg(0, 'hD0);
    cmp("s4_retire", 64'(retire_cnt), 64'(4));

    // Gaps and NOPs in the dependent sequence.
    do_reset();
    li(5, 1); idle(2); send(NOP, 1, 2, 2); li(3, 2); idle(1);
    send(NOP, 3, 3, 3); send(ADD, 1, 2, 3); idle(3); send(SUB, 2, 1, 0);
    idle(6);
    expect_reg(3, 8); expect_reg(0, 'hFE);
    cmp("s5_retire", 64'(retire_cnt), 64'(4));

    // Reset while a MUL is stalling in EX.
    do_reset();
    li(7, 1); send(MUL, 1, 1, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("s6_ready", 64'(inst_ready), 64'(1));
    idle(6);
    expect_reg(3, 0);
    cmp("s6_retire", 64'(retire_cnt), 64'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        idle(gap);
      end
      op = $urandom_range(0, 7);
      send(op, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
           $urandom_range(0, NREG - 1));
    end
    idle(MUL_LAT + 4);
    check_model_regs();
    cmp("rand_retire", 64'(retire_cnt), 64'(retire_exp));
    cmp("queue_drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
